id_ex_operand_stage: RTL and testbench

Operand-fetch and ID/EX pipeline stage directly upstream of the 32-bit ALU. Holds the 32×32 integer register file (x0 hardwired to zero), reads rs1/rs2 with write-back bypass, selects immediate vs. rs2 for the second operand, and registers A/B/ALU select/destination info into a valid/ready pipeline register whose outputs drive the ALU's `A_in`, `B_in`, `ALU_Sel` directly.

---
 rtl/id_ex_operand_stage_pkg.sv | 17 +
 rtl/id_ex_operand_stage_regfile_2r1w.sv | 34 +++
 rtl/id_ex_operand_stage.sv | 103 ++++++++++
 tb/tb_id_ex_operand_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths and ALU operation codes for the operand-fetch / ID-EX stage.
package id_ex_operand_stage_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = $clog2(NREG);
  localparam int ALU_SEL_W  = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_SEL_W-1:0] ALU_NOR = 4'b1100;
  localparam logic [ALU_SEL_W-1:0] ALU_EQ  = 4'b1111;

endpackage

// File: rtl/id_ex_operand_stage_regfile_2r1w.sv
// 32x32 integer register file: two async read ports, one sync write port,
// x0 hardwired to zero, same-cycle write-back forwarded onto the read ports.
module regfile_2r1w
  import id_ex_operand_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [XLEN-1:0]       rdata1_o,
  output logic [XLEN-1:0]       rdata2_o
);

  logic [XLEN-1:0] regs_q [NREG];

  // Array update: reset clears every entry and wins over a write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // x0 is never written, so it never needs forwarding either.
  assign rdata1_o = (raddr1_i == '0)                 ? '0      :
                    (we_i && (waddr_i == raddr1_i))  ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0)                 ? '0      :
                    (we_i && (waddr_i == raddr2_i))  ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/id_ex_operand_stage.sv
// Operand fetch plus one-entry valid/ready ID/EX register feeding the ALU.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [REG_ADDR_W-1:0] Rs1_Addr,
  input  logic [REG_ADDR_W-1:0] Rs2_Addr,
  input  logic [REG_ADDR_W-1:0] Rd_Addr,
  input  logic [XLEN-1:0]       Imm,
  input  logic                  Use_Imm,
  input  logic [ALU_SEL_W-1:0]  ALU_Sel_In,
  input  logic                  Reg_Write_In,
  input  logic                  Flush,
  input  logic                  WB_En,
  input  logic [REG_ADDR_W-1:0] WB_Addr,
  input  logic [XLEN-1:0]       WB_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [XLEN-1:0]       A_in,
  output logic [XLEN-1:0]       B_in,
  output logic [ALU_SEL_W-1:0]  ALU_Sel,
  output logic [REG_ADDR_W-1:0] Rd_Out,
  output logic                  Reg_Write_Out
);

  logic [XLEN-1:0]       rs1_val, rs2_val;
  logic                  accept;
  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       a_q, a_d, b_q, b_d;
  logic [ALU_SEL_W-1:0]  sel_q, sel_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  rw_q, rw_d;

  regfile_2r1w u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we_i     (WB_En),
    .waddr_i  (WB_Addr),
    .wdata_i  (WB_Data),
    .raddr1_i (Rs1_Addr),
    .raddr2_i (Rs2_Addr),
    .rdata1_o (rs1_val),
    .rdata2_o (rs2_val)
  );

  // During a flush the incoming instruction is swallowed, so ready is forced
  // high to let the upstream stage retire it.
  assign In_Ready = !valid_q || Out_Ready || Flush;
  assign accept   = In_Valid && In_Ready && !Flush;

  // Next-state for the pipeline register; data only moves on accept.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    if (Flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      a_d     = rs1_val;
      b_d     = Use_Imm ? Imm : rs2_val;
      sel_d   = ALU_Sel_In;
      rd_d    = Rd_Addr;
      rw_d    = Reg_Write_In;
    end else if (valid_q && Out_Ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= ALU_AND;
      rd_q    <= '0;
      rw_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
    end
  end

  assign Out_Valid     = valid_q;
  assign A_in          = a_q;
  assign B_in          = b_q;
  assign ALU_Sel       = sel_q;
  assign Rd_Out        = rd_q;
  assign Reg_Write_Out = rw_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected operands are queued at
// accept time from a reference register file and compared on consumption.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        In_Valid;
  logic        In_Ready;
  logic [4:0]  Rs1_Addr, Rs2_Addr, Rd_Addr;
  logic [31:0] Imm;
  logic        Use_Imm;
  logic [3:0]  ALU_Sel_In;
  logic        Reg_Write_In;
  logic        Flush;
  logic        WB_En;
  logic [4:0]  WB_Addr;
  logic [31:0] WB_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] A_in, B_in;
  logic [3:0]  ALU_Sel;
  logic [4:0]  Rd_Out;
  logic        Reg_Write_Out;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Rs1_Addr(Rs1_Addr), .Rs2_Addr(Rs2_Addr), .Rd_Addr(Rd_Addr), .Imm(Imm),
    .Use_Imm(Use_Imm), .ALU_Sel_In(ALU_Sel_In), .Reg_Write_In(Reg_Write_In),
    .Flush(Flush), .WB_En(WB_En), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .A_in(A_in), .B_in(B_in),
    .ALU_Sel(ALU_Sel), .Rd_Out(Rd_Out), .Reg_Write_Out(Reg_Write_Out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_regs [32];
  logic        m_valid = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WB_En && WB_Addr == a) return WB_Data;
    return m_regs[a];
  endfunction

  task automatic idle();
    reset = 0; In_Valid = 0; Rs1_Addr = 0; Rs2_Addr = 0; Rd_Addr = 0;
    Imm = 0; Use_Imm = 0; ALU_Sel_In = 0; Reg_Write_In = 0; Flush = 0;
    WB_En = 0; WB_Addr = 0; WB_Data = 0; Out_Ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic use_imm, input logic [3:0] sel,
                       input logic rw);
    In_Valid = 1; Rs1_Addr = rs1; Rs2_Addr = rs2; Rd_Addr = rd; Imm = imm;
    Use_Imm = use_imm; ALU_Sel_In = sel; Reg_Write_In = rw;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    WB_En = 1; WB_Addr = a; WB_Data = d;
  endtask

  // One clock: predict at the negedge, apply the edge, check just after it.
  task automatic cycle();
    exp_t e;
    logic exp_ready, acc, was_reset, was_flush;
    @(negedge clk);
    was_reset = reset;
    was_flush = Flush;
    exp_ready = !m_valid || Out_Ready || Flush;
    chk("in_ready", 32'(In_Ready), 32'(exp_ready));
    if (reset) begin
      sb_q.delete();
      m_valid = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      if (m_valid && sb_q.size() > 0) begin
        if (Out_Ready) begin
          e = sb_q.pop_front();
          chk("a_in", A_in, e.a);
          chk("b_in", B_in, e.b);
          chk("alu_sel", 32'(ALU_Sel), 32'(e.sel));
          chk("rd_out", 32'(Rd_Out), 32'(e.rd));
          chk("rw_out", 32'(Reg_Write_Out), 32'(e.rw));
        end else if (Flush) begin
          void'(sb_q.pop_front());
        end else begin
          chk("hold_a", A_in, sb_q[0].a);
          chk("hold_b", B_in, sb_q[0].b);
        end
      end
      acc = In_Valid && exp_ready && !Flush;
      if (acc) begin
        e.a   = m_read(Rs1_Addr);
        e.b   = Use_Imm ? Imm : m_read(Rs2_Addr);
        e.sel = ALU_Sel_In;
        e.rd  = Rd_Addr;
        e.rw  = Reg_Write_In;
        sb_q.push_back(e);
        m_valid = 1;
      end else if (Flush || Out_Ready) begin
        m_valid = 0;
      end
      if (WB_En && WB_Addr != 5'd0) m_regs[WB_Addr] = WB_Data;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(Out_Valid), 32'(m_valid));
    if (was_reset) begin
      chk("rst_a", A_in, 32'd0);
      chk("rst_b", B_in, 32'd0);
      chk("rst_sel", 32'(ALU_Sel), 32'd0);
      chk("rst_rd", 32'(Rd_Out), 32'd0);
      chk("rst_rw", 32'(Reg_Write_Out), 32'd0);
    end else if (was_flush) begin
      chk("flush_rw", 32'(Reg_Write_Out), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    idle();
    reset = 1;
    cycle();
    cycle();
    idle();

    // Basic read after write-back.
    wb(5, 32'h0000_1234); cycle(); idle();
    issue(5, 0, 1, 32'h0, 0, 4'b0010, 1); cycle(); idle();
    cycle();

    // Same-cycle bypass, then a later array read.
    wb(7, 32'hDEAD_BEEF); issue(7, 5, 2, 32'h0, 0, 4'b0110, 1); cycle(); idle();
    issue(7, 7, 3, 32'h0, 0, 4'b0001, 0); cycle(); idle();
    cycle();

    // x0 write ignored; immediate selects B.
    wb(0, 32'hFFFF_FFFF); cycle(); idle();
    issue(0, 7, 4, 32'hFFFF_FFF0, 1, 4'b0111, 1); cycle(); idle();
    cycle();

    // Stall three cycles with I2 waiting, then release.
    issue(5, 7, 6, 32'h0, 0, 4'b0000, 1); Out_Ready = 0; cycle();
    issue(7, 0, 8, 32'h55, 1, 4'b1100, 1); Out_Ready = 0;
    cycle(); cycle(); cycle();
    Out_Ready = 1; cycle(); idle();
    cycle();

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      idle();
      if ($urandom_range(1, 0) == 1)
        issue(5'($urandom), 5'($urandom), 5'($urandom), $urandom,
              1'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 1) wb(5'($urandom), $urandom);
      Out_Ready = 1'($urandom_range(3, 0) != 0);
      Flush = ($urandom_range(7, 0) == 0);
      cycle();
    end
    idle(); cycle();

    // Flush with a full stage and a new instruction presented.
    issue(5, 7, 9, 32'h0, 0, 4'b1111, 1); Out_Ready = 0; cycle();
    issue(7, 5, 10, 32'h0, 0, 4'b0010, 1); Out_Ready = 0; Flush = 1; cycle(); idle();
    cycle();

    // Reset while stalled with valid data.
    issue(5, 7, 11, 32'h0, 0, 4'b0110, 1); Out_Ready = 0; cycle();
    idle(); Out_Ready = 0; cycle();
    idle(); reset = 1; Flush = 1; wb(9, 32'h1111_2222); Out_Ready = 0; cycle();
    idle(); cycle();
    issue(5, 7, 12, 32'h0, 0, 4'b0010, 1); cycle(); idle();
    issue(9, 0, 13, 32'h0, 0, 4'b0010, 1); cycle(); idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
